// File: rtl/argmax_scan_pkg.sv
// ============================================================================
// Module      : argmax_scan_pkg
// Description : Shared state encoding and default widths for the argmax scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package argmax_scan_pkg;

    localparam int C_SCORE_W     = 16;
    localparam int C_IDX_W       = 4;
    localparam int C_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : argmax_scan_pkg

`default_nettype wire

// File: rtl/argmax_scan_if.sv
// ============================================================================
// Module      : argmax_scan_if
// Description : Score-in / result-out handshake bundle for the argmax scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface argmax_scan_if #(
    parameter int SCORE_W = 16,
    parameter int IDX_W   = 4
);
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] in_score;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   result_idx;
    logic [SCORE_W-1:0] result_score;
    logic               busy;

    modport master (
        output start,
        output in_valid,
        output in_score,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result_idx,
        input  result_score,
        input  busy
    );

    modport slave (
        input  start,
        input  in_valid,
        input  in_score,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result_idx,
        output result_score,
        output busy
    );
endinterface : argmax_scan_if

`default_nettype wire

// File: rtl/argmax_update.sv
// ============================================================================
// Module      : argmax_update
// Description : Strict-greater compare and select of the running {score, idx}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_update #(
    parameter int SCORE_W = 16,
    parameter int IDX_W   = 4
) (
    input  wire logic [SCORE_W-1:0] cur_score,
    input  wire logic [IDX_W-1:0]   cur_idx,
    input  wire logic [SCORE_W-1:0] cand_score,
    input  wire logic [IDX_W-1:0]   cand_idx,
    input  wire logic               first,
    output logic      [SCORE_W-1:0] next_score,
    output logic      [IDX_W-1:0]   next_idx
);

    logic w_take;

    // Strict compare: on equality the held (earlier) entry keeps winning.
    always_comb begin
        w_take     = first || (cand_score > cur_score);
        next_score = cur_score;
        next_idx   = cur_idx;
        if (w_take) begin
            next_score = cand_score;
            next_idx   = cand_idx;
        end
    end

endmodule : argmax_update

`default_nettype wire

// File: rtl/argmax_scan.sv
// ============================================================================
// Module      : argmax_scan
// Description : Scans NUM_CLASSES scores one per beat and reports the argmax.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_scan
    import argmax_scan_pkg::*;
#(
    parameter int SCORE_W     = C_SCORE_W,
    parameter int IDX_W       = C_IDX_W,
    parameter int NUM_CLASSES = C_NUM_CLASSES
) (
    input wire logic     clk,
    input wire logic     rst,
    argmax_scan_if.slave bus
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_count;
    logic [SCORE_W-1:0] r_best_score;
    logic [IDX_W-1:0]   r_best_idx;

    logic               w_accept;
    logic               w_first;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic [SCORE_W-1:0] w_upd_score;
    logic [IDX_W-1:0]   w_upd_idx;

    argmax_update #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_update (
        .cur_score  (r_best_score),
        .cur_idx    (r_best_idx),
        .cand_score (bus.in_score),
        .cand_idx   (r_count),
        .first      (w_first),
        .next_score (w_upd_score),
        .next_idx   (w_upd_idx)
    );

    assign w_first  = (r_count == '0);
    assign w_accept = bus.in_valid && w_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.in_valid && (r_count == C_LAST_IDX)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Beat counter and running best; held across gaps and after the scan so
    // the last result stays visible in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                r_count <= '0;
            end
        end else if (w_accept) begin
            r_count      <= r_count + IDX_W'(1);
            r_best_score <= w_upd_score;
            r_best_idx   <= w_upd_idx;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.busy         = w_busy;
    assign bus.result_idx   = r_best_idx;
    assign bus.result_score = r_best_score;

endmodule : argmax_scan

`default_nettype wire

// File: tb/tb_argmax_scan.sv
// ============================================================================
// Module      : tb_argmax_scan
// Description : Self-checking bench for argmax_scan with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_argmax_scan;

    localparam int C_SW = 16;
    localparam int C_IW = 4;
    localparam int C_N  = 10;

    typedef int score_arr_t [C_N];

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    argmax_scan_if #(.SCORE_W(C_SW), .IDX_W(C_IW)) bus ();

    argmax_scan #(
        .SCORE_W     (C_SW),
        .IDX_W       (C_IW),
        .NUM_CLASSES (C_N)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First maximum wins: earliest class kept on ties.
    function automatic void argmax_q(input int q[$], output int idx, output int best);
        idx  = 0;
        best = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] > best) begin
                best = q[i];
                idx  = i;
            end
        end
    endfunction

    // Reference model: phase 0 idle, 1 collecting scores, 2 result offered.
    int m_phase = 0;
    int m_q[$];
    int m_idx   = 0;
    int m_score = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            m_idx   = 0;
            m_score = 0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase = 1;
                    m_q.delete();
                end
                1: if (bus.in_valid) begin
                    m_q.push_back(int'(bus.in_score));
                    if (m_q.size() == C_N) begin
                        argmax_q(m_q, m_idx, m_score);
                        m_phase = 2;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", int'(bus.in_ready), int'(m_phase == 1));
            check("out_valid", int'(bus.out_valid), int'(m_phase == 2));
            check("busy", int'(bus.busy), int'(m_phase != 0));
            if (m_phase != 1) begin
                check("result_idx", int'(bus.result_idx), m_idx);
                check("result_score", int'(bus.result_score), m_score);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // gap < 0 selects a random 0..2 cycle gap per beat.
    task automatic run_scan(input score_arr_t s, input int gap, input int hold,
                            input bit poke_start, input int exp_idx, input int exp_score);
        int g;
        int wait_cnt;
        do_start();
        for (int i = 0; i < C_N; i++) begin
            bus.in_valid = 1'b1;
            bus.in_score = C_SW'(s[i]);
            bus.start    = poke_start && (i == 2);
            tick();
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) tick();
        end
        wait_cnt = 0;
        while (!bus.out_valid && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("out_valid_timeout", int'(bus.out_valid), 1);
        for (int h = 0; h < hold; h++) begin
            bus.start    = poke_start && (h == 1);
            bus.in_valid = 1'b1;
            tick();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
        end
        check("res_idx", int'(bus.result_idx), exp_idx);
        check("res_score", int'(bus.result_score), exp_score);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_after_handshake", int'(bus.busy), 0);
    endtask

    initial begin
        score_arr_t a;
        int         q[$];
        int         ei;
        int         es;

        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_score  = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_idx", int'(bus.result_idx), 0);
        check("rst_score", int'(bus.result_score), 0);
        rst = 1'b0;
        tick();

        // Basic scan, no gaps.
        a = '{5, 9, 3, 12, 7, 1, 0, 2, 11, 4};
        run_scan(a, 0, 0, 1'b0, 3, 12);

        // Ties keep the earliest class.
        a = '{8, 20, 20, 3, 20, 0, 0, 0, 0, 0};
        run_scan(a, 0, 0, 1'b0, 1, 20);

        // Max on the final class.
        a = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 65535};
        run_scan(a, 0, 0, 1'b0, 9, 65535);

        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_scan(a, 0, 0, 1'b0, 0, 0);

        // Gaps, stalled consumer and stray start pulses.
        a = '{5, 9, 3, 12, 7, 1, 0, 2, 11, 4};
        run_scan(a, 3, 5, 1'b1, 3, 12);

        // Reset abandons a partial scan.
        do_start();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_score = C_SW'(60000 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_ready", int'(bus.in_ready), 0);
        check("midrst_idx", int'(bus.result_idx), 0);
        check("midrst_score", int'(bus.result_score), 0);
        a = '{2, 4, 6, 3, 1, 7, 0, 5, 7, 1};
        run_scan(a, 0, 0, 1'b0, 5, 7);

        // Back-to-back scans with different data.
        a = '{100, 50, 25, 0, 0, 0, 0, 0, 0, 99};
        run_scan(a, 0, 0, 1'b0, 0, 100);
        a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        run_scan(a, 0, 0, 1'b0, 9, 10);

        // Randomized scans; small ranges half the time to provoke ties.
        for (int r = 0; r < 25; r++) begin
            q.delete();
            for (int i = 0; i < C_N; i++) begin
                a[i] = (r % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 65535));
                q.push_back(a[i]);
            end
            argmax_q(q, ei, es);
            run_scan(a, -1, int'($urandom_range(0, 3)), r[2], ei, es);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_argmax_scan

`default_nettype wire
